// File: rtl/branch_tag_allocator_pkg.sv
// Shared branch-mask definitions for the branch tag allocator and its picker.
// The macros are guarded so an including system build can override the width.
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif
`ifndef NUM_B_MASK_BITS
`define NUM_B_MASK_BITS `B_MASK_WIDTH
`endif

package branch_tag_allocator_pkg;

  localparam int unsigned BMaskWidth = `B_MASK_WIDTH;

  typedef logic [`B_MASK_WIDTH-1:0] B_MASK;

endpackage

// File: rtl/br_free_picker.sv
// Combinational in-order picker: hands the lowest free slots to requesting lanes,
// one-hot per lane, stopping at the first lane that cannot be granted.
module br_free_picker #(
  parameter int unsigned NUM_BR = 4,
  parameter int unsigned DISP_W = 2
) (
  input  logic [NUM_BR-1:0]             free_mask,
  input  logic [DISP_W-1:0]             req,
  input  logic                          enable,
  output logic [DISP_W-1:0]             grant,
  output logic [DISP_W-1:0][NUM_BR-1:0] tag
);

  logic [NUM_BR-1:0] avail;
  logic [NUM_BR-1:0] pick;
  logic              chain;

  always_comb begin
    avail = free_mask;
    pick  = '0;
    chain = enable;
    grant = '0;
    tag   = '0;
    for (int j = 0; j < DISP_W; j++) begin
      if (chain && req[j] && (avail != '0)) begin
        // Isolate the lowest set bit of the remaining free slots.
        pick     = avail & (-avail);
        tag[j]   = pick;
        grant[j] = 1'b1;
        avail    = avail & ~pick;
      end else begin
        chain = 1'b0;
      end
    end
  end

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch tag allocator: grants one-hot branch tags with dependency masks, frees them
// on correct resolves, and squashes a mispredicted branch together with its dependents.
module branch_tag_allocator
  import branch_tag_allocator_pkg::*;
#(
  parameter int unsigned NUM_BR = BMaskWidth,
  parameter int unsigned DISP_W = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DISP_W-1:0]               alloc_req,
  input  logic                            resolve_valid,
  input  logic [NUM_BR-1:0]               resolve_tag,
  input  logic                            resolve_mispred,
  output logic [DISP_W-1:0]               alloc_grant,
  output logic [DISP_W-1:0][NUM_BR-1:0]   alloc_tag,
  output logic [DISP_W-1:0][NUM_BR-1:0]   alloc_dep_mask,
  output logic [NUM_BR-1:0]               live_mask,
  output logic [$clog2(NUM_BR+1)-1:0]     free_count,
  output logic                            full,
  output logic                            restore_valid,
  output logic [NUM_BR-1:0]               restore_tag,
  output logic [NUM_BR-1:0]               squash_mask,
  output logic                            resolve_err
);

  localparam int unsigned CntW = $clog2(NUM_BR + 1);

  logic [NUM_BR-1:0]             live_q, live_d;
  logic [NUM_BR-1:0][NUM_BR-1:0] dep_q, dep_d;
  logic                          err_q, err_d;

  logic              tag_onehot;
  logic              tag_live;
  logic              res_ok;
  logic              correct_res;
  logic              mispred_res;
  logic              pick_enable;
  logic [NUM_BR-1:0] squash;

  assign tag_onehot  = (resolve_tag != '0) && ((resolve_tag & (-resolve_tag)) == resolve_tag);
  assign tag_live    = |(resolve_tag & live_q);
  assign res_ok      = resolve_valid && tag_onehot && tag_live;
  assign correct_res = res_ok && !resolve_mispred;
  assign mispred_res = res_ok && resolve_mispred;

  // A mispredict blocks every grant that cycle; reset also holds grants low.
  assign pick_enable = reset && !mispred_res;

  br_free_picker #(
    .NUM_BR (NUM_BR),
    .DISP_W (DISP_W)
  ) u_picker (
    .free_mask (~live_q),
    .req       (alloc_req),
    .enable    (pick_enable),
    .grant     (alloc_grant),
    .tag       (alloc_tag)
  );

  always_comb begin
    alloc_dep_mask    = '0;
    alloc_dep_mask[0] = correct_res ? (live_q & ~resolve_tag) : live_q;
    for (int j = 1; j < DISP_W; j++) begin
      alloc_dep_mask[j] = alloc_dep_mask[j-1] | alloc_tag[j-1];
    end
  end

  // Dependents of the mispredicted tag are exactly the live slots carrying its bit.
  always_comb begin
    squash = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      squash[i] = resolve_tag[i] || (live_q[i] && (|(dep_q[i] & resolve_tag)));
    end
    if (!mispred_res) begin
      squash = '0;
    end
  end

  always_comb begin
    live_d = live_q;
    dep_d  = dep_q;
    err_d  = err_q | (resolve_valid && !(tag_onehot && tag_live));
    if (correct_res) begin
      live_d = live_d & ~resolve_tag;
      for (int i = 0; i < NUM_BR; i++) begin
        dep_d[i] = dep_d[i] & ~resolve_tag;
      end
    end
    if (mispred_res) begin
      live_d = live_d & ~squash;
    end
    for (int j = 0; j < DISP_W; j++) begin
      for (int i = 0; i < NUM_BR; i++) begin
        if (alloc_tag[j][i]) begin
          live_d[i] = 1'b1;
          dep_d[i]  = alloc_dep_mask[j];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live_q <= '0;
      dep_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      live_q <= live_d;
      dep_q  <= dep_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    free_count = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      free_count = free_count + CntW'(!live_q[i]);
    end
  end

  assign live_mask     = live_q;
  assign full          = &live_q;
  assign restore_valid = mispred_res;
  assign restore_tag   = mispred_res ? resolve_tag : '0;
  assign squash_mask   = squash;
  assign resolve_err   = err_q;

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Bench for branch_tag_allocator: directed literal scenarios, then random traffic
// checked every cycle against an age-ordered queue model of the live branches.
module tb_branch_tag_allocator;

  localparam int NB = 4;
  localparam int DW = 2;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [DW-1:0]          alloc_req;
  logic                   resolve_valid;
  logic [NB-1:0]          resolve_tag;
  logic                   resolve_mispred;
  logic [DW-1:0]          alloc_grant;
  logic [DW-1:0][NB-1:0]  alloc_tag;
  logic [DW-1:0][NB-1:0]  alloc_dep_mask;
  logic [NB-1:0]          live_mask;
  logic [2:0]             free_count;
  logic                   full;
  logic                   restore_valid;
  logic [NB-1:0]          restore_tag;
  logic [NB-1:0]          squash_mask;
  logic                   resolve_err;

  int nvec  = 0;
  int nfail = 0;

  // Model: live tags in allocation order, oldest first.
  int mq[$];
  int nq[$];
  bit merr = 1'b0;
  bit nerr = 1'b0;

  branch_tag_allocator #(
    .NUM_BR (NB),
    .DISP_W (DW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .alloc_req       (alloc_req),
    .resolve_valid   (resolve_valid),
    .resolve_tag     (resolve_tag),
    .resolve_mispred (resolve_mispred),
    .alloc_grant     (alloc_grant),
    .alloc_tag       (alloc_tag),
    .alloc_dep_mask  (alloc_dep_mask),
    .live_mask       (live_mask),
    .free_count      (free_count),
    .full            (full),
    .restore_valid   (restore_valid),
    .restore_tag     (restore_tag),
    .squash_mask     (squash_mask),
    .resolve_err     (resolve_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Model state update at each edge, cleared by reset.
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      mq   = nq;
      merr = nerr;
    end
  end

  // Per-cycle comparison against the queue model.
  initial begin : cmp
    logic [NB-1:0] live, base, freem, sq;
    logic [NB-1:0] etag [DW];
    int            elo  [DW];
    logic [DW-1:0] eg;
    int            idx, p, lo;
    bit            oh, tl, cor, mp, chain, keep;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("rst_live", 32'(live_mask), 32'd0);
        chk("rst_grant", 32'(alloc_grant), 32'd0);
        chk("rst_free", 32'(free_count), 32'(NB));
        chk("rst_err", 32'(resolve_err), 32'd0);
        chk("rst_restore", 32'(restore_valid), 32'd0);
        nq.delete();
        nerr = 1'b0;
      end else begin
        live = '0;
        foreach (mq[k]) live[mq[k]] = 1'b1;
        oh  = ($countones(resolve_tag) == 1);
        idx = 0;
        for (int k = 0; k < NB; k++) if (resolve_tag[k]) idx = k;
        tl  = oh && live[idx];
        cor = resolve_valid && tl && !resolve_mispred;
        mp  = resolve_valid && tl && resolve_mispred;
        base = live;
        if (cor) base[idx] = 1'b0;
        freem = ~live;
        chain = !mp;
        eg    = '0;
        for (int j = 0; j < DW; j++) begin
          etag[j] = '0;
          elo[j]  = 0;
          if (chain && alloc_req[j] && freem != '0) begin
            lo = 0;
            for (int i = NB - 1; i >= 0; i--) if (freem[i]) lo = i;
            etag[j][lo] = 1'b1;
            elo[j]      = lo;
            freem[lo]   = 1'b0;
            eg[j]       = 1'b1;
          end else begin
            chain = 1'b0;
          end
        end
        sq = '0;
        p  = 0;
        if (mp) begin
          foreach (mq[k]) if (mq[k] == idx) p = k;
          for (int k = p; k < mq.size(); k++) sq[mq[k]] = 1'b1;
        end
        chk("grant", 32'(alloc_grant), 32'(eg));
        chk("tag0", 32'(alloc_tag[0]), 32'(etag[0]));
        chk("tag1", 32'(alloc_tag[1]), 32'(etag[1]));
        chk("dep0", 32'(alloc_dep_mask[0]), 32'(base));
        chk("dep1", 32'(alloc_dep_mask[1]), 32'(base | etag[0]));
        chk("live", 32'(live_mask), 32'(live));
        chk("free_count", 32'(free_count), 32'(NB - mq.size()));
        chk("full", 32'(full), 32'(mq.size() == NB));
        chk("restore_valid", 32'(restore_valid), 32'(mp));
        chk("restore_tag", 32'(restore_tag), mp ? 32'(resolve_tag) : 32'd0);
        chk("squash", 32'(squash_mask), 32'(sq));
        chk("err", 32'(resolve_err), 32'(merr));
        nq.delete();
        foreach (mq[k]) begin
          keep = !(cor && mq[k] == idx) && !(mp && k >= p);
          if (keep) nq.push_back(mq[k]);
        end
        for (int j = 0; j < DW; j++) if (eg[j]) nq.push_back(elo[j]);
        nerr = merr | (resolve_valid && !tl);
      end
    end
  end

  initial begin
    int k;
    alloc_req       = '0;
    resolve_valid   = 1'b0;
    resolve_tag     = '0;
    resolve_mispred = 1'b0;
    #2;
    chk("d_rst_live", 32'(live_mask), 32'd0);
    chk("d_rst_free", 32'(free_count), 32'd4);
    chk("d_rst_full", 32'(full), 32'd0);
    chk("d_rst_squash", 32'(squash_mask), 32'd0);
    #10 reset = 1'b1;

    // Two lanes allocate from empty.
    step(); alloc_req = 2'b11; #1;
    chk("d036_grant", 32'(alloc_grant), 32'b11);
    chk("d036_tag0", 32'(alloc_tag[0]), 32'b0001);
    chk("d036_tag1", 32'(alloc_tag[1]), 32'b0010);
    chk("d036_dep0", 32'(alloc_dep_mask[0]), 32'b0000);
    chk("d036_dep1", 32'(alloc_dep_mask[1]), 32'b0001);
    step(); alloc_req = 2'b01; #1;
    chk("d036_live", 32'(live_mask), 32'b0011);
    chk("d036_free", 32'(free_count), 32'd2);
    chk("d038_tag0", 32'(alloc_tag[0]), 32'b0100);

    // Mispredict in the middle of a three-deep chain.
    step(); resolve_valid = 1'b1; resolve_tag = 4'b0010; resolve_mispred = 1'b1; #1;
    chk("d038_live", 32'(live_mask), 32'b0111);
    chk("d038_rv", 32'(restore_valid), 32'd1);
    chk("d038_rtag", 32'(restore_tag), 32'b0010);
    chk("d038_squash", 32'(squash_mask), 32'b0110);
    chk("d038_grant", 32'(alloc_grant), 32'b00);

    // Correct resolve with same-cycle allocation.
    step(); resolve_tag = 4'b0001; resolve_mispred = 1'b0; #1;
    chk("d039_live", 32'(live_mask), 32'b0001);
    chk("d039_tag0", 32'(alloc_tag[0]), 32'b0010);
    chk("d039_dep0", 32'(alloc_dep_mask[0]), 32'b0000);
    step(); resolve_valid = 1'b0; #1;
    chk("d039_live2", 32'(live_mask), 32'b0010);
    chk("d040_tag0", 32'(alloc_tag[0]), 32'b0001);

    // Resolve of a tag that is not live.
    step(); alloc_req = 2'b00; resolve_valid = 1'b1; resolve_tag = 4'b1000; #1;
    chk("d040_live", 32'(live_mask), 32'b0011);
    chk("d040_rv", 32'(restore_valid), 32'd0);
    chk("d040_err0", 32'(resolve_err), 32'd0);
    step(); resolve_valid = 1'b0; alloc_req = 2'b11; #1;
    chk("d040_live2", 32'(live_mask), 32'b0011);
    chk("d040_err1", 32'(resolve_err), 32'd1);

    // Full: no grant, but a resolve still lands.
    step(); alloc_req = 2'b01; resolve_valid = 1'b1; resolve_tag = 4'b0100; #1;
    chk("d037_live", 32'(live_mask), 32'b1111);
    chk("d037_full", 32'(full), 32'd1);
    chk("d037_grant", 32'(alloc_grant), 32'b00);
    chk("d037_err", 32'(resolve_err), 32'd1);
    step(); alloc_req = 2'b00; resolve_tag = 4'b1000; #1;
    chk("d037_live2", 32'(live_mask), 32'b1011);
    step(); resolve_valid = 1'b0; alloc_req = 2'b01; #1;
    chk("d041_pre", 32'(live_mask), 32'b0011);

    // Asynchronous reset between edges.
    step(); alloc_req = 2'b00; #1;
    chk("d041_live", 32'(live_mask), 32'b0111);
    #1 reset = 1'b0;
    #1;
    chk("d041_rlive", 32'(live_mask), 32'd0);
    chk("d041_rfree", 32'(free_count), 32'd4);
    chk("d041_rerr", 32'(resolve_err), 32'd0);
    chk("d041_rfull", 32'(full), 32'd0);
    step();
    step(); reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      step();
      if (i % 250 == 249) begin
        alloc_req     = '0;
        resolve_valid = 1'b0;
        resolve_tag   = '0;
        reset         = 1'b0;
        step();
        step();
        reset = 1'b1;
      end else begin
        alloc_req       = DW'($urandom);
        resolve_valid   = ($urandom % 10) < 4;
        resolve_mispred = ($urandom % 10) < 3;
        if (mq.size() > 0 && ($urandom % 10) < 8) begin
          k = $urandom_range(mq.size() - 1, 0);
          resolve_tag = NB'(1 << mq[k]);
        end else begin
          resolve_tag = NB'($urandom);
        end
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
